// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

  localparam int DEF_DW = 17;
  localparam int DEF_VW = 8;
  localparam int CNT_W  = $clog2(DEF_DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then subtract the divisor if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int VW = DEF_VW
) (
  input  logic [VW:0]   partial_rem,
  input  logic          dividend_bit,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   next_rem,
  output logic          quotient_bit
);

  logic [VW:0] trial_s;
  logic [VW:0] divisor_ext_s;

  assign trial_s       = {partial_rem[VW-1:0], dividend_bit};
  assign divisor_ext_s = {1'b0, divisor};

  // Trial compare and conditional subtraction.
  always_comb begin
    next_rem     = trial_s;
    quotient_bit = 1'b0;
    if (trial_s >= divisor_ext_s) begin
      next_rem     = trial_s - divisor_ext_s;
      quotient_bit = 1'b1;
    end else begin
      next_rem     = trial_s;
      quotient_bit = 1'b0;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned divider: one quotient bit per cycle, results returned over valid/ready.
module seq_divider
  import div_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW);

  state_t        state_r;
  logic [DW-1:0] dividend_sr_r;
  logic [VW-1:0] divisor_r;
  logic [VW:0]   prem_r;
  logic [CW-1:0] count_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [DW-1:0] quotient_r;
  logic [VW-1:0] remainder_r;
  logic          div_by_zero_r;

  logic [VW:0]   step_rem_s;
  logic          step_q_s;
  logic [DW-1:0] shifted_s;

  div_step #(.VW(VW)) u_step (
    .partial_rem  (prem_r),
    .dividend_bit (dividend_sr_r[DW-1]),
    .divisor      (divisor_r),
    .next_rem     (step_rem_s),
    .quotient_bit (step_q_s)
  );

  // The dividend register doubles as the quotient accumulator.
  assign shifted_s = {dividend_sr_r[DW-2:0], step_q_s};

  // Control FSM, iteration counter and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      dividend_sr_r <= '0;
      divisor_r     <= '0;
      prem_r        <= '0;
      count_r       <= '0;
      in_ready_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      quotient_r    <= '0;
      remainder_r   <= '0;
      div_by_zero_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            dividend_sr_r <= dividend;
            divisor_r     <= divisor;
            prem_r        <= '0;
            in_ready_r    <= 1'b0;
            if (divisor != '0) begin
              count_r       <= CW'(DW - 1);
              div_by_zero_r <= 1'b0;
              state_r       <= CALC;
            end else begin
              quotient_r    <= '1;
              remainder_r   <= dividend[VW-1:0];
              div_by_zero_r <= 1'b1;
              state_r       <= DONE;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        CALC: begin
          dividend_sr_r <= shifted_s;
          prem_r        <= step_rem_s;
          if (count_r == '0) begin
            quotient_r  <= shifted_s;
            remainder_r <= step_rem_s[VW-1:0];
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            count_r <= count_r - CW'(1);
          end
        end
        DONE: begin
          // A divide-by-zero enters DONE with out_valid still low; it rises one cycle later.
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed latency/backpressure/reset cases plus random traffic.
module tb_seq_divider;

  localparam int DW = 17;
  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  seq_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    logic [VW-1:0] v;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  logic rnd_stall = 1'b0;

  function automatic exp_t model(input logic [DW-1:0] d, input logic [VW-1:0] v);
    exp_t e;
    e.d = d;
    e.v = v;
    if (v == '0) begin
      e.q  = '1;
      e.r  = d[VW-1:0];
      e.dz = 1'b1;
    end else begin
      e.q  = d / {9'd0, v};
      e.r  = VW'(d % {9'd0, v});
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Output monitor: a handshake happens at the posedge following a negedge with valid && ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output got q=%0d r=%0d dz=%0b with no pending operation",
                 quotient, remainder, div_by_zero);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (quotient !== mon_e.q || remainder !== mon_e.r || div_by_zero !== mon_e.dz) begin
          errors++;
          $display("FAIL sb_result %0d/%0d got q=%0d r=%0d dz=%0b want q=%0d r=%0d dz=%0b",
                   mon_e.d, mon_e.v, quotient, remainder, div_by_zero, mon_e.q, mon_e.r, mon_e.dz);
        end
        if (!mon_e.dz) begin
          checks++;
          if ((32'(quotient) * 32'(mon_e.v) + 32'(remainder)) != 32'(mon_e.d) ||
              remainder >= mon_e.v) begin
            errors++;
            $display("FAIL sb_identity %0d/%0d got q=%0d r=%0d", mon_e.d, mon_e.v, quotient, remainder);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_stall) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [VW-1:0] v, output int t_acc);
    int n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_wait in_ready=%b want 1 within 200 cycles", in_ready);
    end
    dividend = d;
    divisor  = v;
    in_valid = 1'b1;
    sb.push_back(model(d, v));
    tick();
    t_acc    = cyc;
    in_valid = 1'b0;
    dividend = DW'($urandom);
    divisor  = VW'($urandom);
  endtask

  task automatic wait_valid(input int t_acc, output int lat);
    int n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    lat = cyc - t_acc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || quotient !== '0 || remainder !== '0 ||
        div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got ov=%b ir=%b q=%0d r=%0d dz=%b want all 0",
               out_valid, in_ready, quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    int t, lat;
    out_ready = 1'b1;
    send(17'd100, 8'd7, t);
    wait_valid(t, lat);
    checks++;
    if (lat != 17) begin
      errors++;
      $display("FAIL basic_latency got %0d want 17", lat);
    end
    checks++;
    if (quotient !== 17'd14 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL basic_value got q=%0d r=%0d dz=%b want 14 2 0", quotient, remainder, div_by_zero);
    end
    tick();
  endtask

  task automatic test_extremes();
    logic [DW-1:0] td[3];
    logic [VW-1:0] tv[3];
    logic [DW-1:0] tq[3];
    logic [VW-1:0] tr[3];
    int t, lat;
    td = '{17'd65025, 17'h1FFFF, 17'd5};
    tv = '{8'd255, 8'd1, 8'd9};
    tq = '{17'd255, 17'h1FFFF, 17'd0};
    tr = '{8'd0, 8'd0, 8'd5};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(td[i], tv[i], t);
      wait_valid(t, lat);
      checks++;
      if (lat != 17 || quotient !== tq[i] || remainder !== tr[i]) begin
        errors++;
        $display("FAIL extreme_%0d got lat=%0d q=%0d r=%0d want lat=17 q=%0d r=%0d",
                 i, lat, quotient, remainder, tq[i], tr[i]);
      end
      tick();
    end
  endtask

  task automatic test_div_zero();
    int t, lat;
    out_ready = 1'b1;
    send(17'd1234, 8'd0, t);
    wait_valid(t, lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL dz_latency got %0d want 1", lat);
    end
    checks++;
    if (quotient !== 17'h1FFFF || remainder !== 8'hD2 || div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dz_value got q=%h r=%h dz=%b want 1ffff d2 1", quotient, remainder, div_by_zero);
    end
    tick();
    send(17'd10, 8'd3, t);
    checks++;
    if (div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL dz_clear got dz=%b want 0 after acceptance", div_by_zero);
    end
    wait_valid(t, lat);
    checks++;
    if (lat != 17 || quotient !== 17'd3 || remainder !== 8'd1 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL after_dz got lat=%0d q=%0d r=%0d dz=%b want 17 3 1 0",
               lat, quotient, remainder, div_by_zero);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int t, lat;
    out_ready = 1'b0;
    send(17'd50000, 8'd13, t);
    wait_valid(t, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      dividend = DW'($urandom);
      divisor  = 8'd1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 17'd3846 || remainder !== 8'd2) begin
        errors++;
        $display("FAIL bp_hold_%0d got ov=%b ir=%b q=%0d r=%0d want 1 0 3846 2",
                 i, out_valid, in_ready, quotient, remainder);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_release got ov=%b ir=%b pending=%0d want 0 1 0", out_valid, in_ready, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int t, lat;
    logic seen;
    out_ready = 1'b1;
    send(17'd1000, 8'd3, t);
    repeat (8) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || quotient !== '0 || remainder !== '0 ||
        div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL midreset_values got ov=%b ir=%b q=%0d r=%0d dz=%b want all 0",
               out_valid, in_ready, quotient, remainder, div_by_zero);
    end
    seen = 1'b0;
    repeat (25) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_quiet got spurious_ov=%b ir=%b want 0 1", seen, in_ready);
    end
    send(17'd300, 8'd16, t);
    wait_valid(t, lat);
    checks++;
    if (lat != 17 || quotient !== 17'd18 || remainder !== 8'd12) begin
      errors++;
      $display("FAIL midreset_next got lat=%0d q=%0d r=%0d want 17 18 12", lat, quotient, remainder);
    end
    tick();
  endtask

  task automatic test_random();
    int t, n;
    rnd_stall = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(DW'($urandom_range(0, 131071)), VW'($urandom_range(1, 255)), t);
    end
    rnd_stall = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL random_drain got pending=%0d want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
